// File: rtl/ddfs_sched.sv
// Round-robin multi-channel phase accumulator: one shared adder steps one channel per clock.
// Optional DDFS_SCHED_SYNC_EN adds sync_i to phase-align every channel at once.
module ddfs_sched #(
    parameter int CHANNELS = 4,
    parameter int ACCUM_W  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_i,
    input  logic [$clog2(CHANNELS)-1:0] ch_i,
    input  logic [ACCUM_W-1:0]          inc_i,
    input  logic                        en_i,
`ifdef DDFS_SCHED_SYNC_EN
    input  logic                        sync_i,
`endif
    output logic                        ack_o,
    output logic                        clip_o,
    output logic [CHANNELS-1:0]         sq_o,
    output logic [CHANNELS-1:0]         rise_o,
    output logic [CHANNELS-1:0]         fall_o
);
    localparam int CH_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0][ACCUM_W-1:0] accum_q, accum_d;
    logic [CHANNELS-1:0][ACCUM_W-1:0] inc_q, inc_d;
    logic [CHANNELS-1:0]              en_q, en_d;
    logic [CHANNELS-1:0]              rise_q, rise_d, fall_q, fall_d;
    logic [CH_W-1:0]                  slot_q, slot_d;
    logic                             clip_q, clip_d, ack_q;
    logic [ACCUM_W-1:0]               sum, inc_wr;

    always_comb begin
        accum_d = accum_q;
        inc_d   = inc_q;
        en_d    = en_q;
        clip_d  = clip_q;
        rise_d  = '0;
        fall_d  = '0;
        slot_d  = (slot_q == CH_W'(CHANNELS - 1)) ? '0 : slot_q + 1'b1;
        sum     = accum_q[slot_q] + inc_q[slot_q];
        // Keeping inc below half scale guarantees at most one MSB edge per service.
        inc_wr  = inc_i[ACCUM_W-1] ? {1'b0, {(ACCUM_W-1){1'b1}}} : inc_i;

        if (en_q[slot_q]) begin
            accum_d[slot_q] = sum;
            rise_d[slot_q]  = !accum_q[slot_q][ACCUM_W-1] &&  sum[ACCUM_W-1];
            fall_d[slot_q]  =  accum_q[slot_q][ACCUM_W-1] && !sum[ACCUM_W-1];
        end

        // The write lands after the service, so a colliding disable clears the fresh sum.
        if (wr_i && (int'(ch_i) < CHANNELS)) begin
            inc_d[ch_i] = inc_wr;
            if (inc_i[ACCUM_W-1]) clip_d = 1'b1;
            if (en_i) begin
                en_d[ch_i] = 1'b1;
            end else begin
                en_d[ch_i]    = 1'b0;
                accum_d[ch_i] = '0;
                rise_d[ch_i]  = 1'b0;
                fall_d[ch_i]  = 1'b0;
            end
        end

`ifdef DDFS_SCHED_SYNC_EN
        if (sync_i) begin
            accum_d = '0;
            slot_d  = '0;
            rise_d  = '0;
            fall_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            accum_q <= '0;
            inc_q   <= '0;
            en_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            slot_q  <= '0;
            clip_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            accum_q <= accum_d;
            inc_q   <= inc_d;
            en_q    <= en_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            slot_q  <= slot_d;
            clip_q  <= clip_d;
            ack_q   <= wr_i;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) sq_o[i] = accum_q[i][ACCUM_W-1];
    end

    assign ack_o  = ack_q;
    assign clip_o = clip_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: doc/ddfs_sched.md
Name: ddfs_sched

Overview:
- Time-multiplexed multi-channel phase-accumulation frequency generator.
- One shared adder serves CHANNELS accumulators in round-robin slots, so each channel updates at clk/CHANNELS.
- Host side programs per-channel increment and enable through a single-cycle write port with acknowledge.
- Feeds low-rate strobes (sample ticks, LED/PWM timebases) to peripherals that would otherwise each need a private fixed accumulator.

Parameters:
CHANNELS, 4, number of accumulator channels (2..16)
ACCUM_W, 16, accumulator / increment width in bits (4..32)

Ports:
clk_i  in  1  clock
rst_i  in  1  async reset, active-low
wr_i  in  1  write strobe, one cycle
ch_i  in  $clog2(CHANNELS)  target channel of write
inc_i  in  ACCUM_W  increment value for write
en_i  in  1  channel enable value for write
ack_o  out  1  write acknowledge pulse
clip_o  out  1  sticky flag: a write was clipped
sq_o  out  CHANNELS  per-channel square output (accum MSB)
rise_o  out  CHANNELS  per-channel one-cycle rising pulse
fall_o  out  CHANNELS  per-channel one-cycle falling pulse

Behaviour:
Reset (rst_i low, async):
- All accum, inc and en registers clear to 0.
- Slot counter clears to 0.
- All outputs are 0.

Slot counter:
- Advances 0,1,..,CHANNELS-1,0,... one step per clock. Free-running, never stalls.

Service of slot k in cycle t:
- If en[k]=1: accum[k] <= accum[k] + inc[k], modulo 2^ACCUM_W (wrap, no saturation).
- If en[k]=0: accum[k] holds.
- rise_o[k] is 1 in cycle t+1 only, when old MSB=0 and new MSB=1.
- fall_o[k] is 1 in cycle t+1 only, when old MSB=1 and new MSB=0.
- At most one bit of rise_o|fall_o is set in any cycle.

sq_o[k]:
- Equals accum[k][ACCUM_W-1] registered, with no extra delay beyond the accum register.

Writes:
- wr_i is sampled each cycle. No back-pressure; every write is accepted.
- ack_o pulses exactly in cycle t+1 for a write in cycle t. Back-to-back writes give back-to-back acks.
- inc_i >= 2^(ACCUM_W-1) is stored as 2^(ACCUM_W-1)-1 and sets clip_o. clip_o clears only on reset.
- en_i=0 written: accum[k] clears to 0 at commit, sq_o[k] drops to 0, and no fall pulse is generated.
- en_i=1 written to a channel that is already enabled: accum[k] is untouched (glitch-free retune).
- en_i=1 written to a disabled channel: accumulation starts from 0 on its next slot.

Write/service collision:
- Write to channel k in the same cycle slot k is serviced: the service uses the old inc/en; the written values apply from the next visit.
- If that write disables the channel, the clear wins over the service result, and any rise/fall due from that service is suppressed.

Frequency:
- Channel output frequency = f_clk * inc / (CHANNELS * 2^ACCUM_W).
- Clipping guarantees inc < 2^(ACCUM_W-1), so at most one MSB edge occurs per service.

Reset mid-operation:
- Reset asserted at any point returns every register to the reset state immediately.
- No partial pulses appear after release.

Optional Feature:
DDFS_SCHED_SYNC_EN
- Defined: adds input port sync_i (1 bit). A sync_i high in cycle t:
  - clears every accum to 0 and forces the slot counter to 0 in cycle t+1;
  - suppresses all rise/fall pulses for cycle t+1;
  - leaves inc, en and clip unchanged.
- A write in the same cycle as sync commits normally. Its disable clear is redundant.
- Undefined: sync_i port is absent and channels free-run.

Test Plan:
- CHANNELS=4, ACCUM_W=8: write ch0 inc=0x20 en=1 -> ack_o next cycle; rise_o[0] every 32 clocks, fall_o[0] 16 clocks after each rise; sq_o[0] 50% duty.
- Write ch2 inc=0xC0 -> stored 0x7F, clip_o=1 and stays 1 until rst_i low; ch2 rise period ~ 4*256/127 clocks, never two edges in one service.
- Ch1 running inc=0x40, write ch1 en=0 while sq_o[1]=1 -> sq_o[1]=0 the cycle after the write, no fall_o[1], no further pulses; re-enable -> first rise after 2 ch1 services.
- Write ch3 in the exact cycle slot=3 -> service uses old inc; new inc effect appears only from the following slot-3 visit; ack_o still one cycle later.
- All 4 channels enabled inc=0x10, then rst_i low mid-cycle -> all outputs 0 asynchronously; after release nothing pulses until rewritten.
- With DDFS_SCHED_SYNC_EN, sync_i pulse while channels run -> all sq_o 0 next cycle, no pulse that cycle, slot restarts at 0, channels phase-aligned thereafter.
